// File: rtl/dvi_pkg.sv
// dvi_pkg: default 640x480@60 timing, sequencer state and phase enums, colour-bar helper
package dvi_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam logic DEF_SYNC_ACT = 1'b1;
  localparam logic [23:0] DEF_FILL_RGB = 24'h000000;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} phase_t;
  // bars: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [23:0] bar_rgb(input logic [2:0] i);
    bar_rgb = {{8{~i[1]}}, {8{~i[2]}}, {8{~i[0]}}};
  endfunction
endpackage

// File: rtl/dvi_axis_counter.sv
// dvi_axis_counter: one raster axis counter with wrap, phase decode and next-cycle active lookahead
module dvi_axis_counter
  import dvi_pkg::*;
#(
  parameter int ACTIVE = 8,
  parameter int FP = 2,
  parameter int SYNC = 2,
  parameter int BP = 2
) (
  input  logic       pix_clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [9:0] cnt,
  output logic       wrap,
  output logic [1:0] phase,
  output logic       nxt_act
);
  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [10:0] E_ACT = 11'(ACTIVE);
  localparam logic [10:0] E_FP = 11'(ACTIVE + FP);
  localparam logic [10:0] E_SYNC = 11'(ACTIVE + FP + SYNC);
  localparam logic [9:0] LAST = 10'(TOTAL - 1);
  if (TOTAL > 1024) begin : g_chk
    $error("dvi_axis_counter: axis total exceeds 1024");
  end
  function automatic phase_t dec(input logic [9:0] v);
    dec = {1'b0, v} < E_ACT ? PH_ACT : {1'b0, v} < E_FP ? PH_FP : {1'b0, v} < E_SYNC ? PH_SYNC : PH_BP;
  endfunction
  logic [9:0] nxt;
  assign wrap = inc && cnt == LAST;
  assign nxt = !rst_n ? '0 : !inc ? cnt : wrap ? '0 : cnt + 10'd1;
  assign phase = dec(cnt);
  assign nxt_act = dec(nxt) == PH_ACT;
  always_ff @(posedge pix_clk) cnt <= nxt;
endmodule

// File: rtl/dvi_timing_sequencer.sv
// dvi_timing_sequencer: DVI raster/TMDS-control sequencer; define DVI_TEST_PATTERN_EN for colour-bar test pattern
module dvi_timing_sequencer
  import dvi_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter logic SYNC_ACT = DEF_SYNC_ACT,
  parameter logic [23:0] FILL_RGB = DEF_FILL_RGB
) (
  input  logic        pix_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [23:0] pix_rgb,
`ifdef DVI_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  d_r,
  output logic [7:0]  d_g,
  output logic [7:0]  d_b,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        line_start,
  output logic        underflow
);
  state_t state, ns;
  logic [9:0] hc, vc;
  logic [1:0] hp, vp;
  logic hw, vw, hna, vna, run, nrun, act, xfer, tp, tp_n;
  logic [23:0] pat;
  assign run = state != IDLE;
  dvi_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .pix_clk(pix_clk), .rst_n(rst_n), .inc(run), .cnt(hc), .wrap(hw), .phase(hp), .nxt_act(hna)
  );
  dvi_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .pix_clk(pix_clk), .rst_n(rst_n), .inc(hw), .cnt(vc), .wrap(vw), .phase(vp), .nxt_act(vna)
  );
  // vw fires only on the last pixel of the frame, so it doubles as frame_end
  assign ns = state == IDLE ? (enable ? RUN : IDLE) : enable ? RUN : (state == STOP && vw) ? IDLE : STOP;
  assign nrun = rst_n && ns != IDLE;
  assign act = run && hp == PH_ACT && vp == PH_ACT;
  assign xfer = pix_valid && pix_ready;
`ifdef DVI_TEST_PATTERN_EN
  logic [2:0] bar;
  assign bar = 3'(13'(hc) * 13'd8 / 13'(H_ACTIVE));
  assign pat = bar_rgb(bar);
  // latch the mode as the next fetch lands on the frame origin
  assign tp_n = nrun && (state == IDLE || vw) ? test_pattern : tp;
  always_ff @(posedge pix_clk) tp <= rst_n && tp_n;
`else
  assign tp = 1'b0;
  assign tp_n = 1'b0;
  assign pat = FILL_RGB;
`endif
  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pix_ready <= 1'b0;
      de <= 1'b0;
      hsync <= ~SYNC_ACT;
      vsync <= ~SYNC_ACT;
      {d_r, d_g, d_b} <= '0;
      x <= '0;
      y <= '0;
      frame_start <= 1'b0;
      line_start <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= ns;
      pix_ready <= nrun && hna && vna && !tp_n;
      de <= act;
      hsync <= (run && hp == PH_SYNC) ? SYNC_ACT : ~SYNC_ACT;
      vsync <= (run && vp == PH_SYNC) ? SYNC_ACT : ~SYNC_ACT;
      {d_r, d_g, d_b} <= !act ? 24'h0 : tp ? pat : xfer ? pix_rgb : FILL_RGB;
      x <= hc;
      y <= vc;
      frame_start <= run && hc == '0 && vc == '0;
      line_start <= run && hc == '0;
      underflow <= underflow || (act && !tp && !xfer);
    end
  end
endmodule

// File: tb/tb_dvi_timing_sequencer.sv
// tb_dvi_timing_sequencer: directed bench on reduced 14x7 raster with hand-computed expectations
module tb_dvi_timing_sequencer;
  logic pix_clk = 1'b0;
  logic rst_n, enable, pix_valid, pix_ready;
  logic [23:0] pix_rgb;
  logic de, hsync, vsync, frame_start, line_start, underflow;
  logic [7:0] d_r, d_g, d_b, src;
  logic [9:0] x, y;
  int checks = 0, errors = 0, nxfer = 0, ex, ey;
  logic ea;
`ifdef DVI_TEST_PATTERN_EN
  logic test_pattern;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  always #5 pix_clk = ~pix_clk;

  dvi_timing_sequencer #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_ACT(1'b1), .FILL_RGB(24'h000000)
  ) dut (
    .pix_clk(pix_clk), .rst_n(rst_n), .enable(enable), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_rgb(pix_rgb),
`ifdef DVI_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .de(de), .hsync(hsync), .vsync(vsync), .d_r(d_r), .d_g(d_g), .d_b(d_b),
    .x(x), .y(y), .frame_start(frame_start), .line_start(line_start), .underflow(underflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one clock; the source model advances its counter on every accepted pixel
  task automatic cyc();
    logic xf;
    xf = pix_valid && pix_ready;
    @(posedge pix_clk);
    #2;
    if (xf) begin
      src++;
      nxfer++;
    end
    pix_rgb = {src, 8'h00, src};
  endtask

  task automatic adv(input int n);
    repeat (n) cyc();
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 64'({de, hsync, vsync, pix_ready, frame_start, line_start, x, y, d_r, d_g, d_b}), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    pix_valid = 1'b0;
    src = 8'd0;
    pix_rgb = 24'h0;
`ifdef DVI_TEST_PATTERN_EN
    test_pattern = 1'b0;
`endif
    adv(3);
    chk_idle("reset");
    chk("reset_uflow", 64'(underflow), 64'(0));
    // release reset and enable together: frame_start two cycles later
    rst_n = 1'b1;
    enable = 1'b1;
    pix_valid = 1'b1;
    src = 8'd0;
    nxfer = 0;
    pix_rgb = 24'h0;
    cyc();
    chk("start_ready", 64'({pix_ready, de, frame_start}), 64'(3'b100));
    cyc();
    for (int i = 0; i < 98; i++) begin
      ex = i % 14;
      ey = i / 14;
      ea = ex < 8 && ey < 4;
      chk("frame0", 64'({de, hsync, vsync, frame_start, line_start, x, y, d_r}),
          64'({ea, ex == 10 || ex == 11, ey == 5, i == 0, ex == 0, 10'(ex), 10'(ey), ea ? 8'(ey * 8 + ex) : 8'd0}));
      if (i < 97) cyc();
    end
    chk("xfers", 64'(nxfer), 64'(32));
    chk("uflow_clean", 64'(underflow), 64'(0));
    // frame 1: drop the pixel destined for x=3,y=1
    adv(17);
    chk("pre_drop", 64'({x, y, underflow}), 64'({10'd2, 10'd1, 1'b0}));
    pix_valid = 1'b0;
    cyc();
    pix_valid = 1'b1;
    chk("fill", 64'({de, x, y, d_r, d_g, d_b, underflow}), 64'({1'b1, 10'd3, 10'd1, 24'h000000, 1'b1}));
    cyc();
    chk("no_refetch", 64'({x, d_r}), 64'({10'd4, 8'd43}));
    // drop enable at y=2; the frame still completes
    adv(10);
    chk("stop_at", 64'({x, y}), 64'({10'd0, 10'd2}));
    enable = 1'b0;
    adv(69);
    chk("last_pix", 64'({x, y, hsync, vsync, de}), 64'({10'd13, 10'd6, 1'b0, 1'b0, 1'b0}));
    cyc();
    chk_idle("idle0");
    chk("uflow_sticky", 64'(underflow), 64'(1));
    adv(3);
    chk_idle("idle3");
    enable = 1'b1;
    cyc();
    chk("reen_ready", 64'({pix_ready, de}), 64'(2'b10));
    cyc();
    chk("reen_start", 64'({frame_start, de, x, y, underflow}), 64'({1'b1, 1'b1, 20'd0, 1'b1}));
    // frame 2: brief enable drop must not interrupt the frame
    adv(5);
    enable = 1'b0;
    adv(5);
    enable = 1'b1;
    adv(87);
    chk("f2_last", 64'({x, y}), 64'({10'd13, 10'd6}));
    cyc();
    chk("f3_start", 64'({frame_start, de, x, y}), 64'({1'b1, 1'b1, 20'd0}));
    // reset mid-frame at x=5,y=2
    adv(33);
    chk("pre_rst", 64'({x, y, de}), 64'({10'd5, 10'd2, 1'b1}));
    rst_n = 1'b0;
    enable = 1'b0;
    cyc();
    chk_idle("mid_rst");
    chk("rst_uflow", 64'(underflow), 64'(0));
    rst_n = 1'b1;
    adv(3);
    chk_idle("post_rst");
`ifdef DVI_TEST_PATTERN_EN
    test_pattern = 1'b1;
    enable = 1'b1;
    cyc();
    chk("tp_ready", 64'(pix_ready), 64'(0));
    cyc();
    chk("tp_start", 64'(frame_start), 64'(1));
    for (int k = 0; k < 8; k++) begin
      chk("tp_bar", 64'({de, pix_ready, x, d_r, d_g, d_b}), 64'({1'b1, 1'b0, 10'(k), bars[k]}));
      cyc();
    end
    chk("tp_uflow", 64'(underflow), 64'(0));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
